// File: rtl/uart_msg_pkg.sv
// Shared definitions for the button-triggered UART message source:
// message ROM, its length/index width and the sequencer FSM states.
package uart_msg_pkg;

  localparam int unsigned MSG_LEN = 13;
  localparam int unsigned IDX_W   = $clog2(MSG_LEN);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(MSG_LEN - 1);

  // "Hello UART!\r\n"
  localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h55,
    8'h41, 8'h52, 8'h54, 8'h21, 8'h0D, 8'h0A
  };

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-level debounce
// counter and a single-cycle pulse on each debounced press (1->0).
module btn_debounce #(
  parameter int unsigned CYCLES = 270000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic pressed_pulse
);

  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic             sync1;
  logic             btn_s;
  logic             btn_db;
  logic             btn_db_q;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain (idle level is high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
    end
  end

  // Accept a new level only after it has differed for CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_db <= 1'b1;
      cnt    <= '0;
    end else if (btn_s == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      btn_db <= btn_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) btn_db_q <= 1'b1;
    else          btn_db_q <= btn_db;
  end

  assign pressed_pulse = btn_db_q & ~btn_db;

endmodule

// File: rtl/uart_msg_sequencer.sv
// Streams a fixed ASCII message to the UART serializer over valid/ready
// each time the debounced button is pressed; counts completed messages.
module uart_msg_sequencer
  import uart_msg_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] msg_count
);

  localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  state_t     state, state_next;
  idx_t       idx, idx_next;
  logic [7:0] count_next;
  logic       press;

  btn_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_n        (btn_n),
    .pressed_pulse(press)
  );

  // Sequencer state, byte index and completed-message counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      msg_count <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      msg_count <= count_next;
    end
  end

  // Next state and handshake outputs; outputs are decoded from registered
  // state only, so they stay stable while the serializer stalls.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    count_next = msg_count;
    tx_valid   = 1'b0;
    tx_data    = '0;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = MSG_ROM[idx];
        if (tx_ready) begin
          if (idx == LAST_IDX) state_next = DONE;
          else                 idx_next   = idx + idx_t'(1);
        end
      end
      DONE: begin
        count_next = msg_count + 8'd1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
